// File: rtl/rv_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_decode_pkg
// Brief    : Shared RV32I decode constants, ALU codes, bundle record type
//            and 32-bit immediate extraction helpers.
// Revision : 1.0 - initial release
// ============================================================================
package rv_decode_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU operation codes ({funct3, alt} encoding; branches compare via SUB)
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  // Decoded control fields; the XLEN-wide immediate travels alongside
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [3:0] alu_sel;
    logic       b_sel;
    logic       imm_sel;
    logic       wdata_sel;
    logic       regs_wen;
    logic [3:0] ram_sel;
    logic       branch;
    logic       jump;
    logic       illegal;
  } dec_bundle_t;

  // Immediates as 32-bit values, already sign-extended to 32 bits
  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_decoder.sv
`default_nettype none
// ============================================================================
// Module   : inst_decoder
// Brief    : Purely combinational RV32I decoder: instruction word in,
//            control bundle and sign-extended XLEN immediate out.
// Revision : 1.0 - initial release
// ============================================================================
module inst_decoder
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output dec_bundle_t     bundle,
  output logic [XLEN-1:0] imm
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [31:0] imm32;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];

  // All 32-bit immediates are sign-correct, so widening is a signed cast
  assign imm = XLEN'($signed(imm32));

  // Opcode table; defaults first so every path is fully assigned
  always_comb begin
    bundle           = '0;
    bundle.rs1       = inst[19:15];
    bundle.rs2       = inst[24:20];
    bundle.rd        = inst[11:7];
    bundle.alu_sel   = ALU_ADD;
    bundle.regs_wen  = 1'b1;
    imm32            = '0;

    if (inst[1:0] != 2'b11) begin
      bundle.illegal  = 1'b1;
      bundle.regs_wen = 1'b0;
    end else begin
      case (opcode)
        OP_R: begin
          bundle.alu_sel = {f3, inst[30]};
        end
        OP_IMM: begin
          bundle.b_sel   = 1'b1;
          bundle.imm_sel = 1'b1;
          imm32          = imm_i(inst);
          // Only the shift-right group uses inst[30] to pick SRLI vs SRAI
          bundle.alu_sel = (f3 == 3'b101) ? {f3, inst[30]} : {f3, 1'b0};
        end
        OP_LOAD: begin
          bundle.b_sel     = 1'b1;
          bundle.imm_sel   = 1'b1;
          bundle.wdata_sel = 1'b1;
          bundle.ram_sel   = {f3, 1'b1};
          imm32            = imm_i(inst);
        end
        OP_STORE: begin
          bundle.b_sel    = 1'b1;
          bundle.imm_sel  = 1'b1;
          bundle.regs_wen = 1'b0;
          bundle.ram_sel  = {f3, 1'b0};
          imm32           = imm_s(inst);
        end
        OP_BRANCH: begin
          bundle.branch   = 1'b1;
          bundle.regs_wen = 1'b0;
          bundle.alu_sel  = ALU_SUB;
          imm32           = imm_b(inst);
        end
        OP_JAL: begin
          bundle.jump = 1'b1;
          imm32       = imm_j(inst);
        end
        OP_JALR: begin
          bundle.jump    = 1'b1;
          bundle.b_sel   = 1'b1;
          bundle.imm_sel = 1'b1;
          imm32          = imm_i(inst);
        end
        OP_LUI, OP_AUIPC: begin
          bundle.b_sel   = 1'b1;
          bundle.imm_sel = 1'b1;
          imm32          = imm_u(inst);
        end
        default: begin
          bundle.illegal  = 1'b1;
          bundle.regs_wen = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : RV32I decode pipeline stage with valid/ready handshakes, an
//            output register plus one skid entry, and a priority flush.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [3:0]      alu_sel,
  output logic            b_sel,
  output logic            imm_sel,
  output logic            wdata_sel,
  output logic            regs_wen,
  output logic [3:0]      ram_sel,
  output logic [XLEN-1:0] imm,
  output logic            branch,
  output logic            jump,
  output logic            illegal
);

  dec_bundle_t     dec_bundle;
  logic [XLEN-1:0] dec_imm;

  dec_bundle_t     out_bundle;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_pc_q;
  logic            out_full;

  dec_bundle_t     skid_bundle;
  logic [XLEN-1:0] skid_imm;
  logic [XLEN-1:0] skid_pc;
  logic            skid_full;

  logic            accept;
  logic            out_free;

  // Decode happens at accept time so both entries hold finished bundles
  inst_decoder #(
    .XLEN (XLEN)
  ) u_inst_decoder (
    .inst   (in_inst),
    .bundle (dec_bundle),
    .imm    (dec_imm)
  );

  // Ready depends only on a register, so no combinational path from out_ready
  assign in_ready = !skid_full;
  assign accept   = in_valid && !skid_full;
  assign out_free = !out_full || out_ready;

  // Two-entry storage: output register refills from skid first, then input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_full    <= 1'b0;
      out_bundle  <= '0;
      out_imm     <= '0;
      out_pc_q    <= '0;
      skid_full   <= 1'b0;
      skid_bundle <= '0;
      skid_imm    <= '0;
      skid_pc     <= '0;
    end else if (flush) begin
      out_full  <= 1'b0;
      skid_full <= 1'b0;
    end else if (out_free) begin
      if (skid_full) begin
        out_bundle <= skid_bundle;
        out_imm    <= skid_imm;
        out_pc_q   <= skid_pc;
        out_full   <= 1'b1;
        skid_full  <= 1'b0;
      end else if (accept) begin
        out_bundle <= dec_bundle;
        out_imm    <= dec_imm;
        out_pc_q   <= in_pc;
        out_full   <= 1'b1;
      end else begin
        out_full <= 1'b0;
      end
    end else if (accept) begin
      skid_bundle <= dec_bundle;
      skid_imm    <= dec_imm;
      skid_pc     <= in_pc;
      skid_full   <= 1'b1;
    end
  end

  assign out_valid = out_full;
  assign out_pc    = out_pc_q;
  assign imm       = out_imm;
  assign rs1       = out_bundle.rs1;
  assign rs2       = out_bundle.rs2;
  assign rd        = out_bundle.rd;
  assign alu_sel   = out_bundle.alu_sel;
  assign b_sel     = out_bundle.b_sel;
  assign imm_sel   = out_bundle.imm_sel;
  assign wdata_sel = out_bundle.wdata_sel;
  assign regs_wen  = out_bundle.regs_wen;
  assign ram_sel   = out_bundle.ram_sel;
  assign branch    = out_bundle.branch;
  assign jump      = out_bundle.jump;
  assign illegal   = out_bundle.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Self-checking bench for decode_stage with a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        b;
    logic        isel;
    logic        wsel;
    logic        wen;
    logic [3:0]  ram;
    logic        br;
    logic        jp;
    logic        ill;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_t;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_sel, ram_sel;
  logic        b_sel, imm_sel, wdata_sel, regs_wen, branch, jump, illegal;

  logic        d64_in_ready, d64_out_valid;
  logic [63:0] d64_out_pc, d64_imm;
  logic [4:0]  d64_rs1, d64_rs2, d64_rd;
  logic [3:0]  d64_alu_sel, d64_ram_sel;
  logic        d64_b_sel, d64_imm_sel, d64_wdata_sel, d64_regs_wen;
  logic        d64_branch, d64_jump, d64_illegal;

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];
  exp_t snap;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd),
    .alu_sel(alu_sel), .b_sel(b_sel), .imm_sel(imm_sel), .wdata_sel(wdata_sel),
    .regs_wen(regs_wen), .ram_sel(ram_sel), .imm(imm), .branch(branch),
    .jump(jump), .illegal(illegal)
  );

  decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d64_in_ready),
    .in_inst(in_inst), .in_pc({32'h0, in_pc}), .flush(flush),
    .out_valid(d64_out_valid), .out_ready(1'b1), .out_pc(d64_out_pc),
    .rs1(d64_rs1), .rs2(d64_rs2), .rd(d64_rd), .alu_sel(d64_alu_sel),
    .b_sel(d64_b_sel), .imm_sel(d64_imm_sel), .wdata_sel(d64_wdata_sel),
    .regs_wen(d64_regs_wen), .ram_sel(d64_ram_sel), .imm(d64_imm),
    .branch(d64_branch), .jump(d64_jump), .illegal(d64_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode written from the instruction-set tables
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic [2:0] f3;
    f3 = i[14:12];
    e = '0;
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
    e.wen = 1'b1; e.pc = pc;
    if (i[1:0] != 2'b11) begin
      e.ill = 1'b1; e.wen = 1'b0;
    end else begin
      case (i[6:0])
        7'h33: e.alu = {f3, i[30]};
        7'h13: begin
          e.b = 1; e.isel = 1; e.imm = {{20{i[31]}}, i[31:20]};
          e.alu = (f3 == 3'd5) ? {f3, i[30]} : {f3, 1'b0};
        end
        7'h03: begin
          e.b = 1; e.isel = 1; e.wsel = 1; e.ram = {f3, 1'b1};
          e.imm = {{20{i[31]}}, i[31:20]};
        end
        7'h23: begin
          e.b = 1; e.isel = 1; e.wen = 0; e.ram = {f3, 1'b0};
          e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
        end
        7'h63: begin
          e.br = 1; e.wen = 0; e.alu = 4'b0001;
          e.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        end
        7'h6f: begin
          e.jp = 1; e.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        end
        7'h67: begin
          e.jp = 1; e.b = 1; e.isel = 1; e.imm = {{20{i[31]}}, i[31:20]};
        end
        7'h37, 7'h17: begin
          e.b = 1; e.isel = 1; e.imm = {i[31:12], 12'h000};
        end
        default: begin
          e.ill = 1; e.wen = 0;
        end
      endcase
    end
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o = '{rs1, rs2, rd, alu_sel, b_sel, imm_sel, wdata_sel, regs_wen,
          ram_sel, branch, jump, illegal, imm, out_pc};
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // One clock: score the handshakes seen before the edge, then advance
  task automatic tick();
    exp_t e;
    #1;
    if (!rst) begin
      if (out_valid && out_ready) begin
        total++;
        assert (sbq.size() > 0) else begin
          bad++;
          $error("FAIL sb_unexpected observed=%0h expected=none", observe());
        end
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("sb_bundle", 128'(observe()), 128'(e));
        end
      end
      if (flush) sbq.delete();
      else if (in_valid && in_ready) sbq.push_back(model(in_inst, in_pc));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && sbq.size() > 0; k++) tick();
    chk("drain_timeout", 128'(sbq.size()), 128'(0));
  endtask

  localparam int NTAB = 8;
  logic [31:0] tab [NTAB] = '{32'h002081B3, 32'h4030D093, 32'h0080A183,
                              32'h0020A423, 32'hFE000EE3, 32'h008000EF,
                              32'h000080E7, 32'h12345017};

  initial begin
    rst = 1'b1; in_valid = 0; in_inst = '0; in_pc = '0; flush = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_fields", 128'(observe()), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // ADDI x1,x0,-5 : one-cycle latency
    out_ready = 1; in_valid = 1; in_inst = 32'hFFB00093; in_pc = 32'h100;
    tick();
    in_valid = 0;
    chk("addi_valid", 128'(out_valid), 128'(1));
    chk("addi_imm", 128'(imm), 128'(32'hFFFFFFFB));
    chk("addi_ctl", 128'({b_sel, regs_wen, rd}), 128'({1'b1, 1'b1, 5'd1}));
    tick();

    // SW then LW back to back at full throughput
    in_valid = 1; in_inst = 32'h0020A423; in_pc = 32'h104;
    tick();
    chk("sw_fields", 128'({regs_wen, ram_sel, imm}), 128'({1'b0, 4'b0100, 32'd8}));
    in_inst = 32'h0080A183; in_pc = 32'h108;
    tick();
    chk("lw_fields", 128'({ram_sel, wdata_sel}), 128'({4'b0101, 1'b1}));
    chk("thru_ready", 128'(in_ready), 128'(1));
    in_valid = 0;
    tick();

    // Stall: two accepts fill both entries, third is refused
    out_ready = 0; in_valid = 1; in_inst = 32'h002081B3; in_pc = 32'h200;
    tick();
    in_inst = 32'h40208233; in_pc = 32'h204;
    tick();
    chk("full_in_ready", 128'(in_ready), 128'(0));
    snap = observe();
    in_inst = 32'h008000EF; in_pc = 32'h208;
    tick();
    chk("stall_stable", 128'(observe()), 128'(snap));
    chk("stall_valid", 128'(out_valid), 128'(1));
    drain();

    // Flush while full with a new instruction offered
    out_ready = 0; in_valid = 1; in_inst = 32'hFE000EE3; in_pc = 32'h300;
    tick();
    chk("beq_fields", 128'({branch, imm}), 128'({1'b1, 32'hFFFFFFFC}));
    in_inst = 32'h000080E7; in_pc = 32'h304;
    tick();
    in_inst = 32'h80000037; in_pc = 32'h308; flush = 1;
    tick();
    flush = 0; in_valid = 0;
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_ready", 128'(in_ready), 128'(1));
    out_ready = 1;
    repeat (3) tick();

    // Flush on an empty stage discards the instruction accepted with it
    in_valid = 1; in_inst = 32'hFFB00093; in_pc = 32'h400; flush = 1;
    tick();
    flush = 0; in_valid = 0;
    chk("flush_accept_drop", 128'(out_valid), 128'(0));
    repeat (2) tick();

    // Illegal word, then LUI checked on the 64-bit instance
    in_valid = 1; in_inst = 32'hFFFFFFFF; in_pc = 32'h500;
    tick();
    chk("illegal", 128'({illegal, regs_wen, ram_sel, branch, jump}), 128'({1'b1, 1'b0, 4'd0, 1'b0, 1'b0}));
    in_inst = 32'h80000037; in_pc = 32'h504;
    tick();
    chk("lui64_imm", 128'(d64_imm), 128'(64'hFFFFFFFF80000000));
    chk("lui32_imm", 128'(imm), 128'(32'h80000000));
    in_inst = 32'h00000013; in_pc = 32'h508;
    tick();
    chk("inst_low_bits", 128'(illegal), 128'(0));
    drain();

    // Randomised traffic through the scoreboard
    for (int n = 0; n < 60; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      in_inst   = tab[$urandom_range(0, NTAB - 1)];
      in_pc     = 32'h1000 + 32'(n * 4);
      tick();
    end
    drain();

    // Reset mid-transfer drops everything held
    out_ready = 0; in_valid = 1; in_inst = 32'h002081B3; in_pc = 32'h600;
    tick();
    in_inst = 32'h40208233; in_pc = 32'h604;
    tick();
    rst = 1'b1; in_valid = 0;
    #1;
    chk("midrst_valid", 128'(out_valid), 128'(0));
    chk("midrst_ready", 128'(in_ready), 128'(1));
    sbq.delete();
    tick();
    rst = 1'b0; out_ready = 1;
    repeat (3) tick();
    chk("post_rst_idle", 128'(out_valid), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter XLEN, default 32, datapath and immediate width; legal values are 32 and 64.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  upstream instruction valid.
REQ-006 in_ready  output  1  stage can accept an instruction.
REQ-007 in_inst  input  32  RV32I instruction word.
REQ-008 in_pc  input  XLEN  instruction address.
REQ-009 flush  input  1  synchronous discard of all held instructions.
REQ-010 out_valid  output  1  decoded bundle valid.
REQ-011 out_ready  input  1  downstream accepts bundle.
REQ-012 out_pc  output  XLEN  address of the decoded instruction.
REQ-013 rs1, rs2, rd  output  5 each  register indices, taken from inst[19:15], inst[24:20] and inst[11:7].
REQ-014 alu_sel  output  4  ALU operation code.
REQ-015 b_sel, imm_sel, wdata_sel, regs_wen  output  1 each  operand-B select, immediate select, write-back-from-memory select and register write enable.
REQ-016 ram_sel  output  4  memory operation code: {funct3, load}.
REQ-017 imm  output  XLEN  sign-extended immediate.
REQ-018 branch, jump, illegal  output  1 each  instruction class flags.

Function
REQ-019 An instruction SHALL be accepted when in_valid && in_ready, and a bundle SHALL be consumed when out_valid && out_ready.
REQ-020 Storage SHALL be two entries (output register plus skid register), and in_ready SHALL be the registered condition "skid entry empty".
REQ-021 On an empty stage, an accepted instruction SHALL appear on out_valid in the next cycle (1-cycle latency).
REQ-022 With out_ready held high, the stage SHALL sustain one instruction per cycle.
REQ-023 Instructions SHALL leave the stage in acceptance order.
REQ-024 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-025 A simultaneous accept and consume on a full output register SHALL move the new bundle into the output register without using the skid entry.
REQ-026 flush SHALL have priority over all other events: both entries are invalidated at the next edge, an instruction accepted in the flush cycle is discarded, and in_ready is 1 in the following cycle.
REQ-027 Decode defaults: alu_sel=0, b_sel=0, imm_sel=0, wdata_sel=0, regs_wen=1, ram_sel=0, branch=0, jump=0, illegal=0, imm=0.
REQ-028 Decode table:
- 0110011 (R): alu_sel={f3,inst[30]}.
- 0010011 (I-arith): b_sel=1, imm_sel=1, I-immediate; alu_sel={f3,inst[30]} for f3=101, otherwise {f3,0}.
- 0000011 (load): b_sel=1, imm_sel=1, wdata_sel=1, ram_sel={f3,1}, I-immediate.
- 0100011 (store): b_sel=1, imm_sel=1, regs_wen=0, ram_sel={f3,0}, S-immediate.
- 1100011 (branch): branch=1, regs_wen=0, alu_sel=0001, B-immediate.
- 1101111 (JAL): jump=1, J-immediate.
- 1100111 (JALR): jump=1, b_sel=1, imm_sel=1, I-immediate.
- 0110111 (LUI) and 0010111 (AUIPC): b_sel=1, imm_sel=1, U-immediate.
REQ-029 Immediates SHALL be sign-extended from inst[31] to XLEN; U-type places inst[31:12] in bits 31:12 with the low 12 bits zero; B-type and J-type have bit 0 zero.
REQ-030 Any other opcode, or inst[1:0] != 11, SHALL set illegal=1 with regs_wen=0, ram_sel=0, branch=0 and jump=0, and the bundle SHALL still be passed downstream.
REQ-031 Decode SHALL be computed from the registered instruction or at accept time, and the decoded fields SHALL be pure functions of the instruction with no latches.

Reset
REQ-032 While rst is high: out_valid=0, in_ready=1, both entries empty, all decoded outputs and out_pc = 0.
REQ-033 Reset asserted mid-transfer SHALL drop every held instruction, and no bundle SHALL be emitted after release until a new accept.

Structure
REQ-034 Opcode constants, ALU codes and the decoded-bundle record type SHALL live in a shared package, rv_decode_pkg.
REQ-035 Combinational decode SHALL be one sub-module, inst_decoder (instruction in, bundle out), instantiated once.

Verification
REQ-036 ADDI x1,x0,-5 (0xFFB00093) with out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFB, b_sel=1, regs_wen=1, rd=1.
REQ-037 SW x2,8(x1) (0x0020A423) -> regs_wen=0, ram_sel=0100, imm=8; LW (0x0080A183) -> ram_sel=0101, wdata_sel=1.
REQ-038 Back-to-back accepts with out_ready=0 -> two accepted, in_ready=0 on the third cycle, bundles drain in order once out_ready=1, and outputs stay stable while stalled.
REQ-039 flush while full plus in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flush-cycle instruction never appears.
REQ-040 BEQ with offset -4 (0xFE000EE3) -> branch=1, imm=0xFFFFFFFC; inst 0xFFFFFFFF -> illegal=1, regs_wen=0; XLEN=64 LUI 0x80000037 -> imm=0xFFFFFFFF80000000.
